// File: rtl/bob_uart_tx.sv
// -----------------------------------------------------------------------------
// bob_uart_tx
//
// Serialises one 9-bit reply word per frame onto an asynchronous serial line:
//   start bit (0), nine data bits LSB first, optional even-parity bit,
//   one stop bit (1). Every bit is held for exactly CLKS_PER_BIT clocks.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   PARITY_EN     1 = append an even-parity bit after the data, 0 = omit it
//
// Ports
//   clock          in   sole clock, all state updates on posedge
//   reset          in   synchronous, active-high reset
//   uart_tx_data   in   [8:0] reply word {plane_id[3:0], msg_type[2:0], msg_action[1:0]}
//   uart_tx_send   in   request to transmit uart_tx_data
//   uart_tx_ready  out  high while idle; a word is accepted on a posedge
//                       where uart_tx_send && uart_tx_ready
//   tx             out  registered serial line, idle high
//   tx_done        out  one-cycle pulse in the first idle cycle after a stop bit
//   dbg_state      out  [2:0] current FSM state, for observation only
//
// Handshake: uart_tx_send/uart_tx_ready form a valid/ready pair. A transfer
// happens on every posedge where both are high; ready stays high in IDLE for
// as long as it takes the requester to raise send, and send is ignored while
// ready is low. The word is latched at the transfer, so uart_tx_data may
// change freely afterwards.
// -----------------------------------------------------------------------------
module bob_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] uart_tx_data,
    input  logic       uart_tx_send,
    output logic       uart_tx_ready,
    output logic       tx,
    output logic       tx_done,
    output logic [2:0] dbg_state
);

    // Baud counter runs 0..CLKS_PER_BIT-1; bit index runs 0..8.
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(9);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(8);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [8:0]        shift_reg;
    logic              parity_bit;
    logic              bit_end;

    // Last clock of the current serial bit.
    assign bit_end = (baud_cnt == BAUD_LAST);

    // Ready is decoded from state alone so it never depends on send.
    assign uart_tx_ready = (state == S_IDLE);
    assign dbg_state     = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (uart_tx_send) begin
                        shift_reg  <= uart_tx_data;
                        // XOR of the data makes the total count of ones even.
                        parity_bit <= ^uart_tx_data;
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        tx         <= 1'b0;
                        state      <= S_START;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= shift_reg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_EN) begin
                                tx    <= parity_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            // The bit on the line is always shift_reg[0];
                            // shift_reg[1] becomes the next one.
                            bit_idx   <= bit_idx + BIT_W'(1);
                            shift_reg <= {1'b0, shift_reg[8:1]};
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        tx_done  <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    tx       <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bob_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_bob_uart_tx
//
// Two instances share one stimulus stream: index 1 has PARITY_EN=1, index 0
// has PARITY_EN=0, both with CLKS_PER_BIT=4. The reference model keeps, per
// instance, a queue holding the expected line level for every remaining clock
// of the frame in flight; an empty queue means idle (line high, ready high).
// -----------------------------------------------------------------------------
module tb_bob_uart_tx;

    localparam int CPB = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset        = 1'b1;
    logic [8:0] uart_tx_data = '0;
    logic       uart_tx_send = 1'b0;

    logic [1:0] ready_o;
    logic [1:0] tx_o;
    logic [1:0] done_o;
    logic [2:0] dbg_state_p;
    logic [2:0] dbg_state_n;

    bob_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_par (
        .clock         (clock),
        .reset         (reset),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_send  (uart_tx_send),
        .uart_tx_ready (ready_o[1]),
        .tx            (tx_o[1]),
        .tx_done       (done_o[1]),
        .dbg_state     (dbg_state_p)
    );

    bob_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_nop (
        .clock         (clock),
        .reset         (reset),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_send  (uart_tx_send),
        .uart_tx_ready (ready_o[0]),
        .tx            (tx_o[0]),
        .tx_done       (done_o[0]),
        .dbg_state     (dbg_state_n)
    );

    // ---------------- scoreboard / model ----------------
    logic exp_q[2][$];
    logic done_m[2];
    int   low_cnt[2];
    int   done_cnt[2];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected line levels for a whole frame, each bit repeated CPB times.
    task automatic push_frame(input int i, input logic [8:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int b = 0; b < 9; b++) bits.push_back(d[b]);
        if (i == 1) bits.push_back(($countones(d) % 2) == 1);
        bits.push_back(1'b1);
        foreach (bits[k])
            for (int c = 0; c < CPB; c++) exp_q[i].push_back(bits[k]);
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 2; i++) begin
            low_cnt[i]  = 0;
            done_cnt[i] = 0;
        end
    endtask

    // ---------------- driver ----------------
    // Present inputs for one clock, advance the model past the edge, compare.
    task automatic step(input logic s, input logic [8:0] d, input logic r);
        logic exp_tx;
        uart_tx_send = s;
        uart_tx_data = d;
        reset        = r;
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                exp_q[i].delete();
                done_m[i] = 1'b0;
            end else if (exp_q[i].size() != 0) begin
                void'(exp_q[i].pop_front());
                done_m[i] = (exp_q[i].size() == 0);
            end else begin
                done_m[i] = 1'b0;
                if (s) push_frame(i, d);
            end
            exp_tx = (exp_q[i].size() == 0) ? 1'b1 : exp_q[i][0];
            chk($sformatf("tx[pe=%0d]", i), tx_o[i], exp_tx);
            chk($sformatf("ready[pe=%0d]", i), ready_o[i], exp_q[i].size() == 0);
            chk($sformatf("done[pe=%0d]", i), done_o[i], done_m[i]);
            if (!ready_o[i]) low_cnt[i]++;
            if (done_o[i]) done_cnt[i]++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 200) begin
            step(1'b0, 9'h000, 1'b0);
            n++;
        end
        if (n >= 200) begin
            errors++;
            $error("FAIL wait_idle: observed=%0d cycles expected<200", n);
        end
        step(1'b0, 9'h000, 1'b0);
        step(1'b0, 9'h000, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [8:0] d;
        logic       s;

        for (int i = 0; i < 2; i++) done_m[i] = 1'b0;
        clr_counts();

        // Reset state.
        repeat (3) step(1'b0, 9'h000, 1'b1);
        step(1'b0, 9'h000, 1'b0);

        // 9'h1A5: 48/44-cycle frames, one tx_done each.
        clr_counts();
        step(1'b1, 9'h1A5, 1'b0);
        wait_idle();
        chk_int("low_1a5[pe=1]", low_cnt[1], 48);
        chk_int("low_1a5[pe=0]", low_cnt[0], 44);
        chk_int("done_1a5[pe=1]", done_cnt[1], 1);
        chk_int("done_1a5[pe=0]", done_cnt[0], 1);

        // All-zero and all-one words (parity 0 and 1).
        step(1'b1, 9'h000, 1'b0);
        wait_idle();
        step(1'b1, 9'h1FF, 1'b0);
        wait_idle();

        // Send and data changes while busy are ignored.
        clr_counts();
        step(1'b1, 9'h1A5, 1'b0);
        repeat (10) step(1'b1, 9'h0F0, 1'b0);
        wait_idle();
        chk_int("done_busy[pe=1]", done_cnt[1], 1);
        chk_int("done_busy[pe=0]", done_cnt[0], 1);
        chk_int("low_busy[pe=1]", low_cnt[1], 48);

        // Back-to-back: send held high, second word taken in the first idle cycle.
        clr_counts();
        step(1'b1, 9'h001, 1'b0);
        repeat (50) step(1'b1, 9'h100, 1'b0);
        wait_idle();
        chk_int("done_b2b[pe=1]", done_cnt[1], 2);
        chk_int("low_b2b[pe=1]", low_cnt[1], 96);

        // Reset during DATA bit 4 (start 4 clks + 4 bits * 4 clks, then 1 more).
        clr_counts();
        step(1'b1, 9'h1A5, 1'b0);
        repeat (21) step(1'b0, 9'h000, 1'b0);
        step(1'b0, 9'h000, 1'b1);
        repeat (3) step(1'b0, 9'h000, 1'b0);
        chk_int("done_rst[pe=1]", done_cnt[1], 0);
        // Reset beats a coincident send.
        step(1'b1, 9'h155, 1'b1);
        step(1'b0, 9'h000, 1'b0);
        step(1'b1, 9'h0A5, 1'b0);
        wait_idle();

        // Random words, random busy-time noise, occasional reset.
        for (int it = 0; it < 25; it++) begin
            d = 9'($urandom_range(0, 511));
            step(1'b1, d, 1'b0);
            for (int c = 0; c < 60; c++) begin
                s = ($urandom_range(0, 3) == 0);
                step(s, 9'($urandom_range(0, 511)), $urandom_range(0, 199) == 0);
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) step(1'b0, 9'h000, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
